// File: rtl/click_classifier.sv
// Groups debounced press pulses into multi-click gestures.
// Emits a one-cycle event carrying the click count, then ignores presses for a holdoff period.
module click_classifier #(
  parameter logic [31:0] WINDOW     = 32'd50_000_000,
  parameter int          MAX_CLICKS = 3,
  parameter logic [31:0] HOLDOFF    = 32'd10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pulse,
  output logic       click_valid,
  output logic [2:0] click_count,
  output logic       busy,
  output logic       dropped
);

  // state     | meaning
  // S_IDLE    | waiting for the first press of a gesture
  // S_COUNT   | counting presses; timer measures idle time since the last press
  // S_HOLDOFF | event just emitted; presses are discarded and flagged as dropped
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_HOLDOFF} state_t;

  localparam logic [31:0] WIN_LAST  = WINDOW - 32'd1;
  localparam logic [31:0] HOLD_LAST = HOLDOFF - 32'd1;
  localparam logic [2:0]  MAX_CNT   = 3'(MAX_CLICKS);

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 3'd0;
      timer       <= 32'd0;
      click_valid <= 1'b0;
      click_count <= 3'd0;
      busy        <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      click_valid <= 1'b0;
      click_count <= 3'd0;
      case (state)
        S_IDLE: begin
          if (btn_pulse) begin
            state <= S_COUNT;
            cnt   <= 3'd1;
            timer <= 32'd0;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end

        S_COUNT: begin
          busy <= 1'b1;
          // A press always beats a timeout landing on the same cycle.
          if (btn_pulse && (cnt + 3'd1) == MAX_CNT) begin
            click_valid <= 1'b1;
            click_count <= MAX_CNT;
            state       <= S_HOLDOFF;
            timer       <= 32'd0;
            cnt         <= 3'd0;
          end else if (btn_pulse) begin
            cnt   <= cnt + 3'd1;
            timer <= 32'd0;
          end else if (timer == WIN_LAST) begin
            click_valid <= 1'b1;
            click_count <= cnt;
            state       <= S_HOLDOFF;
            timer       <= 32'd0;
            cnt         <= 3'd0;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        S_HOLDOFF: begin
          if (btn_pulse) dropped <= 1'b1;
          if (timer == HOLD_LAST) begin
            state <= S_IDLE;
            timer <= 32'd0;
            busy  <= 1'b0;
          end else begin
            timer <= timer + 32'd1;
            busy  <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= 3'd0;
          timer <= 32'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
